// File: rtl/bus_mem_responder.sv
// bus_mem_responder: single-cycle bus slave with RAM, tohost, console FIFO and mtime registers
module bus_mem_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        enable_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wvalue_i,
    output logic [31:0] rvalue_o,
    output logic        done_o,
    output logic [30:0] code_o,
    output logic        cons_valid_o,
    output logic [7:0]  cons_data_o,
    input  logic        cons_ready_i
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] rvalue_q, rvalue_d;
    logic        done_q, done_d;
    logic [30:0] code_q, code_d;
    logic [63:0] mtime_q, mtime_d;
    logic [31:0] shadow_q, shadow_d;
    logic [3:0]  count_q, count_d;
    logic [2:0]  rptr_q, rptr_d, wptr_q, wptr_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  fifo_q [8];
    logic [7:0]  fifo_d [8];

    logic [31:0]   ram_off, mmio_off;
    logic [AW-1:0] ram_idx;
    logic          rd, wr, ram_hit, mmio_hit, empty, full, pop, push_req, push, th_set;

    // Address decode, register reads, tohost/console/mtime next state
    always_comb begin
        rd       = enable_i && (wstrb_i == 4'b0000);
        wr       = enable_i && (wstrb_i != 4'b0000);
        ram_off  = addr_i - MEM_BASE;
        mmio_off = addr_i - MMIO_BASE;
        ram_hit  = ram_off < RAM_BYTES;
        mmio_hit = mmio_off < 32'd16;
        ram_idx  = ram_off[AW+1:2];
        empty    = count_q == 4'd0;
        full     = count_q == 4'd8;
        pop      = !empty && cons_ready_i;
        push_req = wr && mmio_hit && addr_i[3:2] == 2'd1 && wstrb_i[0];
        push     = push_req && (!full || pop);
        th_set   = wr && mmio_hit && addr_i[3:2] == 2'd0 && wstrb_i[0] && wvalue_i[0] && !done_q;
        rvalue_d = 32'h0;
        if (rd && ram_hit)
            rvalue_d = mem[ram_idx];
        else if (rd && mmio_hit)
            rvalue_d = addr_i[3:2] == 2'd0 ? {code_q, done_q} :
                       addr_i[3:2] == 2'd1 ? {29'h0, ovf_q, full, empty} :
                       addr_i[3:2] == 2'd2 ? mtime_q[31:0] : shadow_q;
        done_d   = done_q | th_set;
        code_d   = th_set ? wvalue_i[31:1] : code_q;
        mtime_d  = mtime_q + 64'd1;
        shadow_d = (rd && mmio_hit && addr_i[3:2] == 2'd2) ? mtime_q[63:32] : shadow_q;
        count_d  = count_q + 4'(push) - 4'(pop);
        rptr_d   = rptr_q + 3'(pop);
        wptr_d   = wptr_q + 3'(push);
        ovf_d    = ovf_q | (push_req && full && !pop);
        fifo_d   = fifo_q;
        if (push)
            fifo_d[wptr_q] = wvalue_i[7:0];
    end

    // RAM byte-lane writes; never written while reset is asserted
    always_ff @(posedge clk_i) begin
        if (rstn_i && wr && ram_hit)
            for (int n = 0; n < 4; n++)
                if (wstrb_i[n])
                    mem[ram_idx][8*n +: 8] <= wvalue_i[8*n +: 8];
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalue_q <= 32'h0;
            done_q   <= 1'b0;
            code_q   <= 31'h0;
            mtime_q  <= 64'h0;
            shadow_q <= 32'h0;
            count_q  <= 4'h0;
            rptr_q   <= 3'h0;
            wptr_q   <= 3'h0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < 8; i++)
                fifo_q[i] <= 8'h0;
        end else begin
            rvalue_q <= rvalue_d;
            done_q   <= done_d;
            code_q   <= code_d;
            mtime_q  <= mtime_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            ovf_q    <= ovf_d;
            fifo_q   <= fifo_d;
        end
    end

    assign rvalue_o     = rvalue_q;
    assign done_o       = done_q;
    assign code_o       = code_q;
    assign cons_valid_o = count_q != 4'd0;
    assign cons_data_o  = fifo_q[rptr_q];
endmodule
